// File: rtl/seg_scan_mux_pkg.sv
// Definitions shared by the scan driver and the downstream BCD-to-7-segment decoder.
// BLANK_CODE is the nibble the decoder renders as an unlit digit.
package seg_defs;

    localparam int DIGIT_W    = 4;
    localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;
    localparam int MAX_DIGITS = 8;

    function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] idx);
        return MAX_DIGITS'(1) << idx;
    endfunction

endpackage

// File: rtl/seg_scan_mux_scan_prescaler.sv
// Divides clk down to the digit-slot rate: tick is high on the last cycle of each slot.
module scan_prescaler #(
    parameter int SCAN_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;

    // With SCAN_DIV=1 the counter is pinned at 0 and tick stays high.
    assign tick = (cnt_reg == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Multi-digit 7-segment scan driver with a tear-free shadow frame committed at scan wrap.
// Build option SEG_LEADING_ZERO_BLANK_EN blanks leading zeros of each committed frame.
module seg_scan_mux
    import seg_defs::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 100000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
    output logic [DIGIT_W-1:0]            bcd_out,
    output logic [NUM_DIGITS-1:0]         digit_en,
    output logic                          frame_tick,
    output logic                          pending
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam int FRAME_W = DIGIT_W * NUM_DIGITS;

    logic                 tick;
    logic                 wrap;
    logic                 commit_en;
    logic [IDX_W-1:0]     idx_reg;
    logic [IDX_W-1:0]     idx_next;
    logic [FRAME_W-1:0]   shadow_reg;
    logic                 pending_reg;
    logic                 frame_tick_reg;
    logic [FRAME_W-1:0]   commit_src;
    logic [FRAME_W-1:0]   commit_frame;
    logic [DIGIT_W-1:0]   disp_reg [NUM_DIGITS];

    scan_prescaler #(
        .SCAN_DIV (SCAN_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign wrap = tick && (idx_reg == LAST_IDX);

    always_comb begin
        idx_next = idx_reg;
        if (tick) begin
            idx_next = wrap ? '0 : idx_reg + 1'b1;
        end
    end

    // A load on the wrap edge bypasses the shadow so the newest frame wins.
    assign commit_src = load ? digits_in : shadow_reg;
    assign commit_en  = wrap && (load || pending_reg);

`ifdef SEG_LEADING_ZERO_BLANK_EN
    always_comb begin
        logic lead;
        commit_frame = commit_src;
        lead         = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (lead && (commit_src[i*DIGIT_W +: DIGIT_W] == '0)) begin
                commit_frame[i*DIGIT_W +: DIGIT_W] = BLANK_CODE;
            end else begin
                lead = 1'b0;
            end
        end
    end
`else
    assign commit_frame = commit_src;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg        <= '0;
            shadow_reg     <= '0;
            pending_reg    <= 1'b0;
            frame_tick_reg <= 1'b0;
        end else begin
            idx_reg        <= idx_next;
            frame_tick_reg <= wrap;
            if (load) begin
                shadow_reg <= digits_in;
            end
            if (wrap) begin
                pending_reg <= 1'b0;
            end else if (load) begin
                pending_reg <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_disp
            always_ff @(posedge clk) begin
                if (rst) begin
                    disp_reg[gi] <= BLANK_CODE;
                end else if (commit_en) begin
                    disp_reg[gi] <= commit_frame[gi*DIGIT_W +: DIGIT_W];
                end
            end
        end
    endgenerate

    // Both outputs derive from idx_reg, so they switch together on the same edge.
    assign digit_en   = NUM_DIGITS'(onehot(3'(idx_reg)));
    assign bcd_out    = disp_reg[idx_reg];
    assign frame_tick = frame_tick_reg;
    assign pending    = pending_reg;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux (NUM_DIGITS=4, SCAN_DIV=4) plus a SCAN_DIV=1 instance.
// The reference model derives the active digit from elapsed cycles since reset.
module tb_seg_scan_mux;

    localparam int N = 4;
    localparam int S = 4;
    localparam int P = N * S;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  bcd_out;
    logic [3:0]  digit_en;
    logic        frame_tick;
    logic        pending;
    logic [3:0]  bcd_out2;
    logic [3:0]  digit_en2;
    logic        frame_tick2;
    logic        pending2;

    seg_scan_mux #(.NUM_DIGITS(N), .SCAN_DIV(S)) dut (
        .clk(clk), .rst(rst), .load(load), .digits_in(digits_in),
        .bcd_out(bcd_out), .digit_en(digit_en),
        .frame_tick(frame_tick), .pending(pending)
    );

    seg_scan_mux #(.NUM_DIGITS(N), .SCAN_DIV(1)) dut_fast (
        .clk(clk), .rst(rst), .load(load), .digits_in(digits_in),
        .bcd_out(bcd_out2), .digit_en(digit_en2),
        .frame_tick(frame_tick2), .pending(pending2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] bcd;
        logic [3:0] en;
        logic       pend;
        logic       ft;
        logic [3:0] en2;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state
    int          t = 0;
    logic [3:0]  m_disp [N];
    logic [15:0] m_shadow = '0;
    bit          m_pend = 0;
    bit          m_ft = 0;

    function automatic logic [15:0] blank_frame(input logic [15:0] f);
        logic [15:0] r;
        r = f;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        for (int i = N - 1; i >= 1; i--) begin
            if (r[i*4 +: 4] != 4'd0) break;
            r[i*4 +: 4] = 4'hF;
        end
`endif
        return r;
    endfunction

    task automatic step(input bit r, input bit ld, input logic [15:0] d);
        exp_t        e;
        bit          wrap;
        int          idx;
        logic [15:0] f;
        rst = r;
        load = ld;
        digits_in = d;
        @(posedge clk);
        if (r) begin
            t = 0;
            for (int i = 0; i < N; i++) m_disp[i] = 4'hF;
            m_shadow = '0;
            m_pend = 0;
            m_ft = 0;
        end else begin
            wrap = ((t + 1) % P) == 0;
            t++;
            m_ft = wrap;
            if (wrap && (ld || m_pend)) begin
                f = blank_frame(ld ? d : m_shadow);
                for (int i = 0; i < N; i++) m_disp[i] = f[i*4 +: 4];
                m_pend = 0;
            end else if (ld) begin
                m_shadow = d;
                m_pend = 1;
            end
        end
        idx = (t / S) % N;
        e.bcd  = m_disp[idx];
        e.en   = 4'(1 << idx);
        e.pend = m_pend;
        e.ft   = m_ft;
        e.en2  = 4'(1 << (t % N));
        exp_q.push_back(e);
        if (ld && !r) $display("load %h at t=%0d slot %0d", d, t - 1, (t - 1) % P);
        #1;
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 16'h0);
    endtask

    // Advance until the next edge will start from frame position m.
    task automatic goto_slot(input int m);
        int guard;
        guard = 0;
        while ((t % P) != m && guard < 2 * P) begin
            step(0, 0, 16'h0);
            guard++;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (bcd_out !== e.bcd || digit_en !== e.en || pending !== e.pend ||
                frame_tick !== e.ft || digit_en2 !== e.en2) begin
                miscompares++;
                $display("FAIL outputs vec%0d: got bcd=%h en=%b pend=%b ft=%b en2=%b, want bcd=%h en=%b pend=%b ft=%b en2=%b",
                         vectors, bcd_out, digit_en, pending, frame_tick, digit_en2,
                         e.bcd, e.en, e.pend, e.ft, e.en2);
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) m_disp[i] = 4'hF;

        repeat (3) step(1, 0, 16'h0);
        idle(2 * P);

        goto_slot(5);
        step(0, 1, 16'h1234);
        idle(2 * P);

        goto_slot(2);
        step(0, 1, 16'h1111);
        goto_slot(9);
        step(0, 1, 16'h5678);
        idle(2 * P);

        goto_slot(P - 1);
        step(0, 1, 16'h9999);
        idle(P + 2);

        goto_slot(3);
        step(0, 1, 16'h0040);
        idle(2 * P);

        goto_slot(9);
        step(0, 1, 16'h4321);
        step(1, 0, 16'h0);
        idle(2 * P);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                step(1, 0, 16'h0);
            end else begin
                step(0, $urandom_range(0, 7) == 0, 16'($urandom));
            end
        end
        idle(P);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Multi-digit 7-segment scan driver that sits directly upstream of the team's BCD-to-7-segment decoder.
- Holds a frame of BCD digits and time-multiplexes them, one digit per scan slot.
- Presents the current digit nibble on `bcd_out` (wired to the decoder's 4-bit input) and drives a one-hot digit enable.
- Digit updates are tear-free: a new frame is applied only at a frame boundary.

Parameters:
- NUM_DIGITS, 4: number of display digits; legal range 1..8.
- SCAN_DIV, 100000: clock cycles per digit slot; legal range >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- load  input  1  single-cycle strobe; capture digits_in into the shadow register.
- digits_in  input  4*NUM_DIGITS  BCD frame; digit 0 = bits [3:0], the LS digit.
- bcd_out  output  4  BCD nibble of the active digit, feeds the decoder input x.
- digit_en  output  NUM_DIGITS  one-hot, active-high digit select.
- frame_tick  output  1  one-cycle pulse when the scan wraps to digit 0.
- pending  output  1  shadow frame captured but not yet displayed.

Behaviour:
- Clocking: all state changes on the rising edge of clk. rst is synchronous, active-high, and has priority over every other input.
- Reset values:
  - prescaler = 0, idx = 0.
  - disp_reg = all BLANK_CODE (4'hF per digit); shadow = 0.
  - pending = 0, frame_tick = 0.
  - digit_en = 1 (digit 0 selected), bcd_out = 4'hF.
- Prescaler:
  - Counts 0..SCAN_DIV-1; `tick` is asserted when the count equals SCAN_DIV-1, and the count then wraps to 0.
  - SCAN_DIV=1 gives a tick every cycle.
- Scan index:
  - On tick, idx increments; NUM_DIGITS-1 wraps to 0.
  - NUM_DIGITS=1: idx stays at 0, and every tick is a wrap.
- frame_tick: registered; high for exactly the one cycle following the wrap edge (i.e. the first cycle with idx=0).
- Outputs:
  - digit_en = one-hot(idx); bcd_out = disp_reg[idx].
  - Both are decoded directly from registers and change on the same edge as idx, so they are always mutually consistent and glitch-free.
- Load handshake:
  - load=1 writes digits_in into shadow and sets pending=1.
  - Load while pending: shadow is overwritten (last write wins); pending stays 1.
- Frame commit, on the wrap edge:
  - If pending: disp_reg <= shadow, and pending clears.
  - If load=1 in that same cycle: digits_in goes directly to disp_reg (new data wins) and pending ends 0.
- Non-BCD digits (10..15): passed through unchanged; the decoder's default case renders them blank.
- Reset mid-frame: the scan restarts at digit 0 showing blank; any pending frame is discarded.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: at commit, digits are scanned from MS down to LS. Each digit equal to 0 is replaced with BLANK_CODE until the first non-zero digit is reached. Digit 0 is never blanked. Example: frame 0,0,4,0 (MS..LS) displays F,F,4,0.
- Undefined: frames are committed verbatim.
- Timing and handshake are identical in both builds.

Decomposition:
- Shared package seg_defs holds:
  - DIGIT_W = 4.
  - BLANK_CODE = 4'hF.
  - The one-hot helper function.
- The decoder also uses BLANK_CODE as its blank convention.
- One sub-module, scan_prescaler: parameter SCAN_DIV; ports clk, rst, tick. Instantiated once.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4 unless noted):
- Reset: rst high 3 cycles, then low -> bcd_out=4'hF, digit_en=4'b0001, pending=0; digit_en steps 0001→0010→0100→1000→0001, one step per 4 cycles; frame_tick pulses once per 16 cycles.
- Load 16'h1234 mid-frame -> pending=1 until wrap; the next frame shows digit0=4, digit1=3, digit2=2, digit3=1; pending=0 from then on.
- Load 16'h1111 then 16'h5678 in the same frame -> only 5678 is displayed; 1111 never appears.
- Load 16'h9999 on the exact wrap cycle -> the frame starting at that edge shows 9 on digit 0; pending stays 0.
- Load 16'h0040 -> with SEG_LEADING_ZERO_BLANK_EN, digits 3..0 = F,F,4,0; without it, 0,0,4,0.
- Assert rst while digit 2 is active and a frame is pending -> next cycle: idx=0, bcd_out=F, pending=0; SCAN_DIV=1 variant: digit_en advances every cycle.
